control_ext_alu: RTL and testbench
==================================

CONTROL_EXT_ALU -- requirements
Module: control_ext_alu

Interface
REQ-001 The module SHALL have the following ports, listed as name, direction, width and meaning:
  clk       in   1   single clock.
  rst       in   1   asynchronous, active-low reset.
  op        in   6   instr[31:26].
  func      in   6   instr[5:0].
  shamt     in   5   instr[10:6].
  imm16     in  16   instr[15:0].
  busA      in  32   rs register data.
  busB      in  32   rt register data.
  cur_pc    in  30   word PC, i.e. byte PC[31:2].
  regWr, regDst, Extop, alusrc, memWr, memtoreg, checkover, branch, jump   out  1 each   control signals.
  aluop     out  5   ALU operation code.
  imm32     out 32   extended immediate.
  result    out 32   ALU result.
  zero      out  1   result==0.
  overflow  out  1   checked signed overflow.
  ovf_sticky out 1   latched overflow.
REQ-002 All outputs except ovf_sticky SHALL be purely combinational, with zero cycles of latency.

Function
REQ-003 aluop encoding SHALL be:
  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU.
  8 SLL, 9 SRL, 10 SRA (shift B by shamt).
  11 SLLV, 12 SRLV, 13 SRAV (shift B by A[4:0]).
  14 LUI ({B[15:0],16'h0}).
  15 LINK ({cur_pc,2'b00}+4).
  All other codes: result = 0.
REQ-004 R-type instructions (op=000000) SHALL decode with regWr=1 and regDst=1:
  func 100000 add (ADD, checkover=1).
  func 100001 addu (ADD).
  func 100010 sub (SUB, checkover=1).
  func 100011 subu (SUB).
  func 100100 and, 100101 or, 100110 xor, 100111 nor.
  func 101010 slt, 101011 sltu.
  func 000000 sll, 000010 srl, 000011 sra.
  func 000100 sllv, 000110 srlv, 000111 srav.
REQ-005 jr (func 001000) SHALL set jump=1, regWr=0 and aluop=ADD.
REQ-006 jalr (func 001001) SHALL set jump=1, regWr=1, regDst=1 and aluop=LINK.
REQ-007 I-type instructions SHALL decode with alusrc=1, regWr=1 and regDst=0:
  addi 001000 (ADD, Extop=1, checkover=1).
  addiu 001001 (ADD, Extop=1).
  slti 001010 (SLT, Extop=1).
  sltiu 001011 (SLTU, Extop=1).
  andi 001100 (AND, Extop=0).
  ori 001101 (OR, Extop=0).
  xori 001110 (XOR, Extop=0).
  lui 001111 (LUI, Extop=0).
REQ-008 Loads SHALL decode as ADD, alusrc=1, Extop=1, regWr=1, regDst=0 and memtoreg=1, for lw 100011, lb 100000 and lbu 100100.
REQ-009 Stores SHALL decode as ADD, alusrc=1, Extop=1, memWr=1 and regWr=0, for sw 101011 and sb 101000.
REQ-010 beq 000100 and bne 000101 SHALL decode as SUB, alusrc=0, Extop=1 and branch=1.
REQ-011 j 000010 SHALL set jump=1.
REQ-012 jal 000011 SHALL set jump=1, regWr=1 and aluop=LINK; regDst is don't-care, driven 0.
REQ-013 Any signal not listed for an instruction SHALL be 0.
REQ-014 An unrecognized op/func SHALL drive all control outputs to 0 and aluop=ADD.
REQ-015 imm32 SHALL be {{16{imm16[15]}},imm16} when Extop=1, and {16'h0,imm16} otherwise.
REQ-016 The ALU B operand SHALL be imm32 when alusrc=1, and busB otherwise; the A operand SHALL be busA.
REQ-017 Arithmetic SHALL be 32-bit modulo 2^32.
REQ-018 SLT/SLTU SHALL produce 32'h1 or 32'h0.
REQ-019 SRA/SRAV SHALL sign-fill.
REQ-020 A shift amount of 0 SHALL return B unchanged.
REQ-021 overflow SHALL be 1 only when checkover=1 and the signed ADD/SUB result overflows:
  ADD: operand signs equal and result sign differs.
  SUB: operand signs differ and result sign differs from A.
REQ-022 overflow SHALL be 0 for all other aluop values.
REQ-023 result SHALL still be the wrapped value when overflow=1.
REQ-024 zero SHALL equal (result==32'h0) for every aluop, including LINK and shifts.
REQ-025 ovf_sticky SHALL set to 1 on a rising clk edge when overflow=1.
REQ-026 Once set, ovf_sticky SHALL hold until reset; a later overflow=0 SHALL NOT clear it.

Reset
REQ-027 While rst=0, ovf_sticky SHALL be forced to 0 immediately, asynchronously, independent of clk.
REQ-028 Combinational outputs SHALL be unaffected by rst.
REQ-029 On rst release, ovf_sticky SHALL first capture at the next rising clk edge.
REQ-030 If rst is asserted in the same cycle as an overflow, reset SHALL win and ovf_sticky SHALL be 0.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  V1: add with busA=7FFFFFFF, busB=1 -> result 80000000, overflow=1; ovf_sticky=1 after the next clk edge.
  V2: addu with the same operands -> result 80000000, overflow=0; regWr=1, regDst=1.
  V3: ori with imm16=8001, busA=0 -> Extop=0, imm32=00008001, result 00008001.
  V3b: addi with imm16=FFFF, busA=5 -> result 4.
  V4: beq with busA=busB=1234 -> aluop=SUB, zero=1, branch=1.
  V4b: bne with busA=1 and busB=2 -> zero=0.
  V5: sra with busB=80000000, shamt=4 -> F8000000; sltu with A=1, B=FFFFFFFF -> 1; slt with the same operands -> 0.
  V6: jal with cur_pc=00000C00 -> result 00003004, jump=1, regWr=1; then rst low mid-operation with ovf_sticky=1 -> ovf_sticky=0 without a clock edge.

Source files
------------

// File: rtl/control_ext_alu.sv
// Single-cycle MIPS-style control decoder, immediate extender and 32-bit ALU.
// Adds a sticky overflow flag that is cleared asynchronously by an active-low reset.
module control_ext_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic [29:0] cur_pc,
  output logic        regWr,
  output logic        regDst,
  output logic        Extop,
  output logic        alusrc,
  output logic        memWr,
  output logic        memtoreg,
  output logic        checkover,
  output logic        branch,
  output logic        jump,
  output logic [4:0]  aluop,
  output logic [31:0] imm32,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        ovf_sticky
);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_SLLV = 5'd11;
  localparam logic [4:0] ALU_SRLV = 5'd12;
  localparam logic [4:0] ALU_SRAV = 5'd13;
  localparam logic [4:0] ALU_LUI  = 5'd14;
  localparam logic [4:0] ALU_LINK = 5'd15;

  logic [31:0] alu_b;

  // Every recognised case sets its own regWr/regDst so unknown encodings fall through to all-zero.
  always_comb begin
    regWr     = 1'b0;
    regDst    = 1'b0;
    Extop     = 1'b0;
    alusrc    = 1'b0;
    memWr     = 1'b0;
    memtoreg  = 1'b0;
    checkover = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    aluop     = ALU_ADD;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_ADD; checkover = 1'b1; end
          6'b100001: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_ADD; end
          6'b100010: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SUB; checkover = 1'b1; end
          6'b100011: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SUB; end
          6'b100100: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_AND; end
          6'b100101: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_OR; end
          6'b100110: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_XOR; end
          6'b100111: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_NOR; end
          6'b101010: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SLT; end
          6'b101011: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SLTU; end
          6'b000000: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SLL; end
          6'b000010: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SRL; end
          6'b000011: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SRA; end
          6'b000100: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SLLV; end
          6'b000110: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SRLV; end
          6'b000111: begin regWr = 1'b1; regDst = 1'b1; aluop = ALU_SRAV; end
          6'b001000: begin jump = 1'b1; aluop = ALU_ADD; end
          6'b001001: begin jump = 1'b1; regWr = 1'b1; regDst = 1'b1; aluop = ALU_LINK; end
          default: ;
        endcase
      end
      6'b001000: begin alusrc = 1'b1; regWr = 1'b1; aluop = ALU_ADD;  Extop = 1'b1; checkover = 1'b1; end
      6'b001001: begin alusrc = 1'b1; regWr = 1'b1; aluop = ALU_ADD;  Extop = 1'b1; end
      6'b001010: begin alusrc = 1'b1; regWr = 1'b1; aluop = ALU_SLT;  Extop = 1'b1; end
      6'b001011: begin alusrc = 1'b1; regWr = 1'b1; aluop = ALU_SLTU; Extop = 1'b1; end
      6'b001100: begin alusrc = 1'b1; regWr = 1'b1; aluop = ALU_AND; end
      6'b001101: begin alusrc = 1'b1; regWr = 1'b1; aluop = ALU_OR; end
      6'b001110: begin alusrc = 1'b1; regWr = 1'b1; aluop = ALU_XOR; end
      6'b001111: begin alusrc = 1'b1; regWr = 1'b1; aluop = ALU_LUI; end
      6'b100011, 6'b100000, 6'b100100: begin
        aluop = ALU_ADD; alusrc = 1'b1; Extop = 1'b1; regWr = 1'b1; memtoreg = 1'b1;
      end
      6'b101011, 6'b101000: begin
        aluop = ALU_ADD; alusrc = 1'b1; Extop = 1'b1; memWr = 1'b1;
      end
      6'b000100, 6'b000101: begin aluop = ALU_SUB; Extop = 1'b1; branch = 1'b1; end
      6'b000010: jump = 1'b1;
      6'b000011: begin jump = 1'b1; regWr = 1'b1; aluop = ALU_LINK; end
      default: ;
    endcase
  end

  assign imm32 = Extop ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
  assign alu_b = alusrc ? imm32 : busB;

  always_comb begin
    result = '0;
    case (aluop)
      ALU_ADD:  result = busA + alu_b;
      ALU_SUB:  result = busA - alu_b;
      ALU_AND:  result = busA & alu_b;
      ALU_OR:   result = busA | alu_b;
      ALU_XOR:  result = busA ^ alu_b;
      ALU_NOR:  result = ~(busA | alu_b);
      ALU_SLT:  result = {31'd0, $signed(busA) < $signed(alu_b)};
      ALU_SLTU: result = {31'd0, busA < alu_b};
      ALU_SLL:  result = alu_b << shamt;
      ALU_SRL:  result = alu_b >> shamt;
      ALU_SRA:  result = $signed(alu_b) >>> shamt;
      ALU_SLLV: result = alu_b << busA[4:0];
      ALU_SRLV: result = alu_b >> busA[4:0];
      ALU_SRAV: result = $signed(alu_b) >>> busA[4:0];
      ALU_LUI:  result = {alu_b[15:0], 16'h0000};
      ALU_LINK: result = {cur_pc, 2'b00} + 32'd4;
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'h0);

  always_comb begin
    overflow = 1'b0;
    if (checkover) begin
      if (aluop == ALU_ADD)
        overflow = (busA[31] == alu_b[31]) && (result[31] != busA[31]);
      else if (aluop == ALU_SUB)
        overflow = (busA[31] != alu_b[31]) && (result[31] != busA[31]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ovf_sticky <= 1'b0;
    else if (overflow)
      ovf_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_control_ext_alu.sv
// Directed vector table for control_ext_alu plus hand sequences for the sticky
// overflow flag and its asynchronous reset.
module tb_control_ext_alu;

  logic        clk;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [31:0] busA;
  logic [31:0] busB;
  logic [29:0] cur_pc;
  logic        regWr, regDst, Extop, alusrc, memWr, memtoreg, checkover, branch, jump;
  logic [4:0]  aluop;
  logic [31:0] imm32;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        ovf_sticky;

  int checks = 0;
  int errors = 0;

  control_ext_alu dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .shamt(shamt), .imm16(imm16),
    .busA(busA), .busB(busB), .cur_pc(cur_pc),
    .regWr(regWr), .regDst(regDst), .Extop(Extop), .alusrc(alusrc), .memWr(memWr),
    .memtoreg(memtoreg), .checkover(checkover), .branch(branch), .jump(jump),
    .aluop(aluop), .imm32(imm32), .result(result), .zero(zero),
    .overflow(overflow), .ovf_sticky(ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {regWr,regDst,Extop,alusrc,memWr,memtoreg,checkover,branch,jump}
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [31:0] a;
    logic [31:0] b;
    logic [29:0] pc;
    logic [8:0]  ctrl;
    logic [4:0]  aluop;
    logic [31:0] imm32;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                       input logic [15:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [29:0] pc);
    op = o; func = f; shamt = s; imm16 = i; busA = a; busB = b; cur_pc = pc;
  endtask

  initial begin
    vecs[0]  = '{"add_ovf",  6'h00, 6'h20, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h00000001, 30'd0, 9'b110000100, 5'd0,  32'h00000000, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{"addu",     6'h00, 6'h21, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h00000001, 30'd0, 9'b110000000, 5'd0,  32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vecs[2]  = '{"ori",      6'h0D, 6'h00, 5'd0, 16'h8001, 32'h00000000, 32'hDEADBEEF, 30'd0, 9'b100100000, 5'd3,  32'h00008001, 32'h00008001, 1'b0, 1'b0};
    vecs[3]  = '{"addi_neg", 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h00000005, 32'h00000000, 30'd0, 9'b101100100, 5'd0,  32'hFFFFFFFF, 32'h00000004, 1'b0, 1'b0};
    vecs[4]  = '{"beq",      6'h04, 6'h00, 5'd0, 16'h0010, 32'h00001234, 32'h00001234, 30'd0, 9'b001000010, 5'd1,  32'h00000010, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{"bne",      6'h05, 6'h00, 5'd0, 16'h0000, 32'h00000001, 32'h00000002, 30'd0, 9'b001000010, 5'd1,  32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[6]  = '{"sra",      6'h00, 6'h03, 5'd4, 16'h0000, 32'h00000000, 32'h80000000, 30'd0, 9'b110000000, 5'd10, 32'h00000000, 32'hF8000000, 1'b0, 1'b0};
    vecs[7]  = '{"sltu",     6'h00, 6'h2B, 5'd0, 16'h0000, 32'h00000001, 32'hFFFFFFFF, 30'd0, 9'b110000000, 5'd7,  32'h00000000, 32'h00000001, 1'b0, 1'b0};
    vecs[8]  = '{"slt",      6'h00, 6'h2A, 5'd0, 16'h0000, 32'h00000001, 32'hFFFFFFFF, 30'd0, 9'b110000000, 5'd6,  32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{"jal",      6'h03, 6'h00, 5'd0, 16'h0000, 32'h00000000, 32'h00000000, 30'h00000C00, 9'b100000001, 5'd15, 32'h00000000, 32'h00003004, 1'b0, 1'b0};
    vecs[10] = '{"sub_ovf",  6'h00, 6'h22, 5'd0, 16'h0000, 32'h80000000, 32'h00000001, 30'd0, 9'b110000100, 5'd1,  32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[11] = '{"sll_zero", 6'h00, 6'h00, 5'd0, 16'h0000, 32'h00000000, 32'h12345678, 30'd0, 9'b110000000, 5'd8,  32'h00000000, 32'h12345678, 1'b0, 1'b0};
    vecs[12] = '{"srav",     6'h00, 6'h07, 5'd0, 16'h0000, 32'h00000004, 32'h80000000, 30'd0, 9'b110000000, 5'd13, 32'h00000000, 32'hF8000000, 1'b0, 1'b0};
    vecs[13] = '{"lw",       6'h23, 6'h00, 5'd0, 16'hFFFC, 32'h00000100, 32'h00000000, 30'd0, 9'b101101000, 5'd0,  32'hFFFFFFFC, 32'h000000FC, 1'b0, 1'b0};
    vecs[14] = '{"sw",       6'h2B, 6'h00, 5'd0, 16'h0008, 32'h00000010, 32'h00000000, 30'd0, 9'b001110000, 5'd0,  32'h00000008, 32'h00000018, 1'b0, 1'b0};
    vecs[15] = '{"lui",      6'h0F, 6'h00, 5'd0, 16'h1234, 32'h00000000, 32'h00000000, 30'd0, 9'b100100000, 5'd14, 32'h00001234, 32'h12340000, 1'b0, 1'b0};
    vecs[16] = '{"unknown",  6'h3F, 6'h00, 5'd0, 16'h8000, 32'h00000001, 32'h00000002, 30'd0, 9'b000000000, 5'd0,  32'h00008000, 32'h00000003, 1'b0, 1'b0};
    vecs[17] = '{"jr",       6'h00, 6'h08, 5'd0, 16'h0000, 32'h00000010, 32'h00000020, 30'd0, 9'b000000001, 5'd0,  32'h00000000, 32'h00000030, 1'b0, 1'b0};
    vecs[18] = '{"jalr",     6'h00, 6'h09, 5'd0, 16'h0000, 32'h00000000, 32'h00000000, 30'd1, 9'b110000001, 5'd15, 32'h00000000, 32'h00000008, 1'b0, 1'b0};
    vecs[19] = '{"nor",      6'h00, 6'h27, 5'd0, 16'h0000, 32'h00000000, 32'h00000000, 30'd0, 9'b110000000, 5'd5,  32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[20] = '{"unk_func", 6'h00, 6'h3F, 5'd0, 16'h0000, 32'h00000003, 32'h00000004, 30'd0, 9'b000000000, 5'd0,  32'h00000000, 32'h00000007, 1'b0, 1'b0};

    rst = 1'b0;
    drive(6'h00, 6'h21, 5'd0, 16'h0000, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 chk("reset_sticky", {31'd0, ovf_sticky}, 32'd0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].func, vecs[i].shamt, vecs[i].imm16, vecs[i].a, vecs[i].b, vecs[i].pc);
      #1;
      chk({vecs[i].name, "_ctrl"}, {23'd0, regWr, regDst, Extop, alusrc, memWr, memtoreg, checkover, branch, jump},
          {23'd0, vecs[i].ctrl});
      chk({vecs[i].name, "_aluop"}, {27'd0, aluop}, {27'd0, vecs[i].aluop});
      chk({vecs[i].name, "_imm32"}, imm32, vecs[i].imm32);
      chk({vecs[i].name, "_result"}, result, vecs[i].result);
      chk({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].zero});
      chk({vecs[i].name, "_ovf"}, {31'd0, overflow}, {31'd0, vecs[i].ovf});
    end

    // Sticky flag: clear, set on edge, hold through non-overflow cycles.
    @(negedge clk);
    rst = 1'b0;
    drive(6'h00, 6'h21, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h1, '0);
    @(negedge clk);
    rst = 1'b1;
    drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h1, '0);
    #1 chk("sticky_before_edge", {31'd0, ovf_sticky}, 32'd0);
    @(posedge clk);
    #1 chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
    @(negedge clk) drive(6'h00, 6'h21, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h1, '0);
    @(posedge clk);
    #1 chk("sticky_hold", {31'd0, ovf_sticky}, 32'd1);

    // Async reset mid-cycle during jal, then reset beating a concurrent overflow.
    @(negedge clk) drive(6'h03, 6'h00, 5'd0, 16'h0000, '0, '0, 30'h00000C00);
    #2 rst = 1'b0;
    #1;
    chk("async_clear", {31'd0, ovf_sticky}, 32'd0);
    chk("jal_result_in_reset", result, 32'h00003004);
    chk("jal_jump_in_reset", {31'd0, jump}, 32'd1);
    drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h1, '0);
    #1 chk("ovf_in_reset", {31'd0, overflow}, 32'd1);
    @(posedge clk);
    #1 chk("reset_wins", {31'd0, ovf_sticky}, 32'd0);
    @(negedge clk);
    drive(6'h00, 6'h21, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h1, '0);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("no_ovf_after_release", {31'd0, ovf_sticky}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
